tbus_arb: RTL
=============

Name: tbus_arb

Overview:
- Two-master to one-slave arbiter for the trinity bus (tbus), placed between the backend and channel_arb.
- Master 0 (M0) is the LSU load/store port. It is speculative and flushable on redirect.
- Master 1 (M1) is a non-speculative secondary requester, e.g. a prefetcher or page walker. It is never flushed.
- Round-robin grant, one outstanding slave transaction, request latching, response routing back to the owner.

Parameters:
- ADDR_W, 64, tbus index width.
- DATA_W, 64, write/read data and write mask width.
- TYPE_W, 2, tbus_operation_type width.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- redirect_valid  in  1  pipeline flush; affects M0 only
- mN_index_valid  in  1  request valid (N = 0,1; same set per master)
- mN_index_ready  out  1  one-cycle pulse: request accepted by the slave
- mN_index  in  ADDR_W  address
- mN_write_data  in  DATA_W  store data
- mN_write_mask  in  DATA_W  byte/bit mask
- mN_operation_type  in  TYPE_W  read/write type, passed through unchanged
- mN_operation_done  out  1  one-cycle completion pulse
- mN_read_data  out  DATA_W  read data, valid with done
- s_index_valid  out  1  request to slave (channel_arb tbus port)
- s_index_ready  in  1  slave accept
- s_index  out  ADDR_W
- s_write_data  out  DATA_W
- s_write_mask  out  DATA_W
- s_operation_type  out  TYPE_W
- s_read_data  in  DATA_W
- s_operation_done  in  1  slave completion pulse

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, owner=0, rr_last=1 so M0 wins the first tie, drop=0.
  - All outputs 0, including s_* payload registers.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any mN_index_valid: grant one master and latch its index, data, mask and type into the s_* registers. Set s_index_valid=1 the next cycle. State -> ISSUE.
  - Latency: request seen at cycle t gives s_index_valid high at t+1.
  - Round-robin on a tie: grant the master not equal to rr_last. rr_last updates to the granted master.
  - If M0 is the only requester and redirect_valid=1 in the same cycle, M0 is not granted.
- ISSUE:
  - s_index_valid held high and payload held stable until s_index_valid & s_index_ready.
  - On accept: pulse mN_index_ready for the owner for 1 cycle, deassert s_index_valid, state -> WAIT.
  - Masters hold valid/payload until their ready pulse.
- WAIT:
  - On s_operation_done: if drop=0, pulse owner mN_operation_done=1 with mN_read_data=s_read_data, registered so it appears 1 cycle after s_operation_done.
  - Then state -> IDLE and clear drop.
  - Re-arbitration happens in IDLE, giving a 1-cycle bubble between transactions.
- Redirect with owner=M0:
  - In ISSUE before accept: abort. s_index_valid -> 0 the next cycle, no ready, no done, state -> IDLE.
  - In ISSUE in the same cycle as accept: the accept wins and the transaction proceeds. Set drop=1; no ready pulse is issued.
  - In WAIT: the slave transaction completes. Set drop=1 and suppress m0_operation_done.
- Redirect with owner=M1: no effect.
- s_operation_done outside WAIT: ignored.
- Done/ready pulses go only to the owner; the non-owner's outputs stay 0.
- A master's request is never granted twice: its valid is expected low in the cycle after its ready pulse.
- Asynchronous reset mid-transaction:
  - Immediate return to IDLE with all outputs 0.
  - A pending slave done after reset is ignored because state is IDLE.

Test Plan:
- M0 only: m0_index=0x8000_1000, type read. s_index_ready at cycle 3, s_operation_done at cycle 6 with s_read_data=0xDEAD_BEEF_0000_0001 -> s_index_valid cycles 2-3, m0_index_ready pulse at cycle 3, m0_operation_done=1 with read_data=0xDEAD_BEEF_0000_0001 at cycle 7.
- Both masters request continuously from reset -> grant order M0, M1, M0, M1. No master granted twice in a row while the other is waiting.
- M1 write: mask=0x0000_0000_FFFF_FFFF, data=0x1234 -> s_write_mask/s_write_data match exactly and are held stable while s_index_ready=0 for 5 cycles.
- redirect_valid during M0 ISSUE, before accept -> s_index_valid drops the next cycle, no m0_index_ready, no m0_operation_done. A pending M1 is granted next.
- redirect_valid during M0 WAIT -> the slave done is consumed, m0_operation_done stays 0, FSM returns to IDLE. A redirect during M1 WAIT still yields m1_operation_done.
- reset_n pulsed low mid-WAIT -> all outputs 0 immediately. A subsequent s_operation_done produces no mN_operation_done.

Source files
------------

// File: rtl/tbus_arb_if.sv
// Trinity-bus (tbus) request/response bundle.
// The "master" modport is the requester side and the "slave" modport is the responder side.
interface tbus_arb_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int TYPE_W = 2
);
   logic              index_valid;
   logic              index_ready;
   logic [ADDR_W-1:0] index;
   logic [DATA_W-1:0] write_data;
   logic [DATA_W-1:0] write_mask;
   logic [TYPE_W-1:0] operation_type;
   logic              operation_done;
   logic [DATA_W-1:0] read_data;

   modport master (
      output index_valid, index, write_data, write_mask, operation_type,
      input  index_ready, operation_done, read_data
   );

   modport slave (
      input  index_valid, index, write_data, write_mask, operation_type,
      output index_ready, operation_done, read_data
   );
endinterface

// File: rtl/tbus_arb.sv
// Two-master to one-slave tbus arbiter.
// M0 is the speculative LSU port and is flushed by redirect_valid.
// M1 is a non-speculative requester and is never flushed.
// Grants are round-robin. At most one slave transaction is in flight.
// Responses are routed back to the master that owns the transaction.
module tbus_arb #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int TYPE_W = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       redirect_valid,
   tbus_arb_if.slave  m0,
   tbus_arb_if.slave  m1,
   tbus_arb_if.master s
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic              owner;      // 0 = M0, 1 = M1
   logic              rr_last;    // master granted most recently
   logic              drop;       // M0 was flushed after the slave accepted its request

   logic [ADDR_W-1:0] index_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] wmask_q;
   logic [TYPE_W-1:0] type_q;

   logic              m0_done_q;
   logic              m1_done_q;
   logic [DATA_W-1:0] m0_rdata_q;
   logic [DATA_W-1:0] m1_rdata_q;

   logic              req0;
   logic              req1;
   logic              grant_any;
   logic              grant_sel;
   logic              flush_m0;
   logic              accept;
   logic              done_fire;

   // Qualify requests, pick the round-robin winner, and decode the handshake events.
   always_comb begin
      // A flushed M0 request is never granted, even when M1 also requests.
      req0      = m0.index_valid & ~redirect_valid;
      req1      = m1.index_valid;
      grant_any = req0 | req1;
      grant_sel = (req0 & req1) ? ~rr_last : req1;
      flush_m0  = redirect_valid & (owner == 1'b0);
      accept    = (state == ISSUE) & s.index_ready;
      done_fire = (state == WAIT) & s.operation_done & ~drop & ~flush_m0;
   end

   // State register.
   // NOTE: all sequential state uses non-blocking assignments, so each register samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default first, so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      unique case (state)
         IDLE:    if (grant_any) state_nxt = ISSUE;
         ISSUE:   if (accept) state_nxt = WAIT;
                  else if (flush_m0) state_nxt = IDLE;
         WAIT:    if (s.operation_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Ownership, round-robin history, and drop flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         owner   <= 1'b0;
         rr_last <= 1'b1;
         drop    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               drop <= 1'b0;
               if (grant_any) begin
                  owner   <= grant_sel;
                  rr_last <= grant_sel;
               end
            end
            ISSUE: if (accept && flush_m0) drop <= 1'b1;
            WAIT: begin
               if (s.operation_done) drop <= 1'b0;
               else if (flush_m0)    drop <= 1'b1;
            end
            default: drop <= 1'b0;
         endcase
      end
   end

   // Latch the winner's payload at grant time. The payload then stays stable while the request is in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         index_q <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         type_q  <= '0;
      end else if (state == IDLE && grant_any) begin
         index_q <= grant_sel ? m1.index          : m0.index;
         wdata_q <= grant_sel ? m1.write_data     : m0.write_data;
         wmask_q <= grant_sel ? m1.write_mask     : m0.write_mask;
         type_q  <= grant_sel ? m1.operation_type : m0.operation_type;
      end
   end

   // Register the completion one cycle after the slave's done. Only the owner sees it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m0_done_q  <= 1'b0;
         m1_done_q  <= 1'b0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else begin
         m0_done_q  <= done_fire & ~owner;
         m1_done_q  <= done_fire &  owner;
         m0_rdata_q <= (done_fire && !owner) ? s.read_data : '0;
         m1_rdata_q <= (done_fire &&  owner) ? s.read_data : '0;
      end
   end

   // Drive the outputs. A flushed M0 receives no ready pulse, even when the slave accepts.
   always_comb begin
      s.index_valid     = (state == ISSUE);
      s.index           = index_q;
      s.write_data      = wdata_q;
      s.write_mask      = wmask_q;
      s.operation_type  = type_q;
      m0.index_ready    = accept & ~owner & ~redirect_valid;
      m1.index_ready    = accept &  owner;
      m0.operation_done = m0_done_q;
      m0.read_data      = m0_rdata_q;
      m1.operation_done = m1_done_q;
      m1.read_data      = m1_rdata_q;
   end

endmodule
